id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 121 ++++++++++++
 tb/tb_id_ex_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register with load-use hazard detection.
//
// Purpose:
//   Registers the decoded instruction from ID into EX. Detects a load-use
//   hazard against the instruction currently in EX and inserts a one-cycle
//   bubble. Supports branch flush and an EX back-pressure hold.
//
// Edge priority: rst_i > flush_i > ex_hold_i > hazard > capture.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   id_valid_i              ID holds a real instruction
//   id_rs_data_i/rt_data_i  register-file read data
//   id_imm_i, id_pc4_i      sign-extended immediate, PC+4
//   id_rs/rt/rd_addr_i      register addresses
//   id_ctrl_i               {reg_write, mem_read, mem_write, mem_to_reg,
//                            alu_src, alu_op[3:0]}
//   wb_reg_write_i, wb_rd_addr_i, wb_rd_data_i   writeback port
//   flush_i                 kill the ID instruction (branch taken)
//   ex_hold_i               EX not ready; hold all EX outputs
//   ex_*_o                  registered EX-stage copies
//   stall_o                 combinational; freeze PC and IF/ID
//
// Configuration macro:
//   ID_EX_WB_BYPASS_EN  when defined, a same-cycle writeback to rs/rt is
//                       forwarded into the captured register data.
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [DATA_W-1:0] id_pc4_i,
    input  logic [4:0]        id_rs_addr_i,
    input  logic [4:0]        id_rt_addr_i,
    input  logic [4:0]        id_rd_addr_i,
    input  logic [8:0]        id_ctrl_i,
    input  logic              wb_reg_write_i,
    input  logic [4:0]        wb_rd_addr_i,
    input  logic [DATA_W-1:0] wb_rd_data_i,
    input  logic              flush_i,
    input  logic              ex_hold_i,
    output logic              ex_valid_o,
    output logic [8:0]        ex_ctrl_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [DATA_W-1:0] ex_pc4_o,
    output logic [4:0]        ex_rs_addr_o,
    output logic [4:0]        ex_rt_addr_o,
    output logic [4:0]        ex_rd_addr_o,
    output logic              stall_o
);

    localparam int CTRL_MEM_READ = 7;

    logic              hazard;
    logic [DATA_W-1:0] rs_next;
    logic [DATA_W-1:0] rt_next;

    // Load in EX whose destination is a source of the ID instruction.
    // Register 0 is hard-wired zero and never creates a dependency.
    always_comb begin
        hazard = ex_valid_o
              && ex_ctrl_o[CTRL_MEM_READ]
              && (ex_rd_addr_o != 5'd0)
              && id_valid_i
              && ((ex_rd_addr_o == id_rs_addr_i) || (ex_rd_addr_o == id_rt_addr_i));
    end

    assign stall_o = hazard | ex_hold_i;

`ifdef ID_EX_WB_BYPASS_EN
    // Register file is read in the same cycle it is written; forward the
    // writeback value so the captured operand is not stale.
    always_comb begin
        rs_next = id_rs_data_i;
        rt_next = id_rt_data_i;
        if (wb_reg_write_i && (wb_rd_addr_i != 5'd0)) begin
            if (wb_rd_addr_i == id_rs_addr_i) rs_next = wb_rd_data_i;
            if (wb_rd_addr_i == id_rt_addr_i) rt_next = wb_rd_data_i;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_reg_write_i, wb_rd_addr_i, wb_rd_data_i};
    assign rs_next   = id_rs_data_i;
    assign rt_next   = id_rt_data_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || (!ex_hold_i && hazard)) begin
            // Reset, flush and load-use bubble all leave EX empty and zeroed.
            ex_valid_o   <= 1'b0;
            ex_ctrl_o    <= '0;
            ex_rs_data_o <= '0;
            ex_rt_data_o <= '0;
            ex_imm_o     <= '0;
            ex_pc4_o     <= '0;
            ex_rs_addr_o <= '0;
            ex_rt_addr_o <= '0;
            ex_rd_addr_o <= '0;
        end else if (!ex_hold_i) begin
            ex_valid_o   <= id_valid_i;
            ex_ctrl_o    <= id_valid_i ? id_ctrl_i : '0;
            ex_rs_data_o <= rs_next;
            ex_rt_data_o <= rt_next;
            ex_imm_o     <= id_imm_i;
            ex_pc4_o     <= id_pc4_i;
            ex_rs_addr_o <= id_rs_addr_i;
            ex_rt_addr_o <= id_rt_addr_i;
            ex_rd_addr_o <= id_rd_addr_i;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage -- self-checking bench for id_ex_stage.
// Directed scenarios followed by a randomized run against a behavioural
// model of the EX register contents.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam logic [8:0] CTRL_LW  = 9'b1_1_0_1_1_0000;
    localparam logic [8:0] CTRL_ADD = 9'b1_0_0_0_0_0010;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
    logic [4:0]    id_rs_addr, id_rt_addr, id_rd_addr;
    logic [8:0]    id_ctrl;
    logic          wb_we;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          flush, hold;

    logic          ex_valid;
    logic [8:0]    ex_ctrl;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [4:0]    ex_rs_addr, ex_rt_addr, ex_rd_addr;
    logic          stall;

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_stage #(.DATA_W(DW)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data),
        .id_imm_i(id_imm), .id_pc4_i(id_pc4),
        .id_rs_addr_i(id_rs_addr), .id_rt_addr_i(id_rt_addr), .id_rd_addr_i(id_rd_addr),
        .id_ctrl_i(id_ctrl),
        .wb_reg_write_i(wb_we), .wb_rd_addr_i(wb_addr), .wb_rd_data_i(wb_data),
        .flush_i(flush), .ex_hold_i(hold),
        .ex_valid_o(ex_valid), .ex_ctrl_o(ex_ctrl),
        .ex_rs_data_o(ex_rs_data), .ex_rt_data_o(ex_rt_data),
        .ex_imm_o(ex_imm), .ex_pc4_o(ex_pc4),
        .ex_rs_addr_o(ex_rs_addr), .ex_rt_addr_o(ex_rt_addr), .ex_rd_addr_o(ex_rd_addr),
        .stall_o(stall)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          valid;
        logic [8:0]    ctrl;
        logic [DW-1:0] rs, rt, imm, pc4;
        logic [4:0]    rsa, rta, rda;
    } ex_t;

    ex_t mdl;

    // A load in EX blocks an ID instruction that reads its (nonzero) target.
    function automatic logic model_stall(ex_t m);
        logic dep;
        dep = m.valid && m.ctrl[7] && m.rda != 0 && id_valid &&
              (m.rda == id_rs_addr || m.rda == id_rt_addr);
        return dep || hold;
    endfunction

    function automatic logic [DW-1:0] model_operand(logic [4:0] a, logic [DW-1:0] d);
`ifdef ID_EX_WB_BYPASS_EN
        if (wb_we && wb_addr != 0 && wb_addr == a) return wb_data;
`endif
        return d;
    endfunction

    function automatic ex_t model_next(ex_t m);
        ex_t n;
        logic dep;
        dep = model_stall(m) && !hold;
        if (rst || flush) return '0;
        if (hold) return m;
        if (dep) return '0;
        n.valid = id_valid;
        n.ctrl  = id_valid ? id_ctrl : 9'd0;
        n.rs    = model_operand(id_rs_addr, id_rs_data);
        n.rt    = model_operand(id_rt_addr, id_rt_data);
        n.imm   = id_imm;
        n.pc4   = id_pc4;
        n.rsa   = id_rs_addr;
        n.rta   = id_rt_addr;
        n.rda   = id_rd_addr;
        return n;
    endfunction

    function automatic ex_t dut_state();
        return {ex_valid, ex_ctrl, ex_rs_data, ex_rt_data, ex_imm, ex_pc4,
                ex_rs_addr, ex_rt_addr, ex_rd_addr};
    endfunction

    // Advance one clock; the model follows the same inputs.
    task automatic step();
        mdl = model_next(mdl);
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [8:0] c, input logic [4:0] rsa,
                          input logic [4:0] rta, input logic [4:0] rda,
                          input logic [DW-1:0] rsd, input logic [DW-1:0] rtd);
        id_valid = v; id_ctrl = c;
        id_rs_addr = rsa; id_rt_addr = rta; id_rd_addr = rda;
        id_rs_data = rsd; id_rt_data = rtd;
        id_imm = $urandom; id_pc4 = $urandom;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1; flush = 0; hold = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
        set_id(1, CTRL_LW, 5'd3, 5'd4, 5'd5, $urandom, $urandom);
        step();
        step();
        n_cmp++;
        if (dut_state() !== '0) begin
            n_bad++; $display("FAIL reset_state: got %h want 0", dut_state());
        end
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL reset_stall: got %b want 0", stall);
        end
        hold = 1; #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL reset_stall_hold: got %b want 1", stall);
        end
        hold = 0;
        rst = 0;
    endtask

    task automatic test_load_use();
        set_id(1, CTRL_LW, 5'd1, 5'd2, 5'd8, 32'h11, 32'h22);
        step();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_ctrl !== CTRL_LW || ex_rd_addr !== 5'd8) begin
            n_bad++; $display("FAIL lw_capture: got v=%b c=%h rd=%0d want v=1 c=%h rd=8",
                              ex_valid, ex_ctrl, ex_rd_addr, CTRL_LW);
        end
        set_id(1, CTRL_ADD, 5'd8, 5'd9, 5'd10, 32'h33, 32'h44);
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL loaduse_stall: got %b want 1", stall);
        end
        step();
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 9'd0) begin
            n_bad++; $display("FAIL loaduse_bubble: got v=%b c=%h want v=0 c=0", ex_valid, ex_ctrl);
        end
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL loaduse_release: got stall=%b want 0", stall);
        end
        step();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_ctrl !== CTRL_ADD || ex_rs_addr !== 5'd8 || ex_rs_data !== 32'h33) begin
            n_bad++; $display("FAIL loaduse_add: got v=%b c=%h rs=%0d d=%h want v=1 c=%h rs=8 d=33",
                              ex_valid, ex_ctrl, ex_rs_addr, ex_rs_data, CTRL_ADD);
        end
    endtask

    task automatic test_flush_priority();
        set_id(1, CTRL_LW, 5'd1, 5'd2, 5'd8, 32'h55, 32'h66);
        step();
        set_id(1, CTRL_ADD, 5'd8, 5'd9, 5'd10, 32'h77, 32'h88);
        flush = 1; hold = 1; #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL flush_stall: got %b want 1", stall);
        end
        step();
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || ex_rs_data !== '0 || ex_rd_addr !== 5'd0) begin
            n_bad++; $display("FAIL flush_bubble: got v=%b c=%h d=%h rd=%0d want all 0",
                              ex_valid, ex_ctrl, ex_rs_data, ex_rd_addr);
        end
        flush = 0; hold = 0;
    endtask

    task automatic test_hold();
        ex_t held;
        set_id(1, CTRL_ADD, 5'd3, 5'd4, 5'd6, 32'h1234, 32'h9);
        step();
        n_cmp++;
        if (ex_rs_data !== 32'h1234) begin
            n_bad++; $display("FAIL hold_setup: got %h want 1234", ex_rs_data);
        end
        held = dut_state();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
            #1;
            n_cmp++;
            if (stall !== 1'b1) begin
                n_bad++; $display("FAIL hold_stall: got %b want 1", stall);
            end
            step();
            n_cmp++;
            if (ex_rs_data !== 32'h1234 || ex_valid !== 1'b1 || ex_ctrl !== CTRL_ADD) begin
                n_bad++; $display("FAIL hold_keep: got rs=%h v=%b c=%h want rs=1234 v=1 c=%h",
                                  ex_rs_data, ex_valid, ex_ctrl, CTRL_ADD);
            end
        end
        hold = 0;
        set_id(1, CTRL_ADD, 5'd11, 5'd12, 5'd13, 32'h5678, 32'h0);
        step();
        n_cmp++;
        if (ex_rs_data !== 32'h5678 || ex_rs_addr !== 5'd11) begin
            n_bad++; $display("FAIL hold_release: got rs=%h a=%0d want 5678 a=11", ex_rs_data, ex_rs_addr);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want;
`ifdef ID_EX_WB_BYPASS_EN
        want = 32'hDEADBEEF;
`else
        want = 32'h0;
`endif
        wb_we = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        set_id(1, CTRL_ADD, 5'd5, 5'd7, 5'd14, 32'h0, 32'hA5);
        step();
        n_cmp++;
        if (ex_rs_data !== want || ex_rt_data !== 32'hA5) begin
            n_bad++; $display("FAIL bypass_rs: got rs=%h rt=%h want rs=%h rt=a5", ex_rs_data, ex_rt_data, want);
        end
        set_id(1, CTRL_ADD, 5'd7, 5'd5, 5'd14, 32'h1, 32'h0);
        step();
        n_cmp++;
        if (ex_rt_data !== want || ex_rs_data !== 32'h1) begin
            n_bad++; $display("FAIL bypass_rt: got rt=%h rs=%h want rt=%h rs=1", ex_rt_data, ex_rs_data, want);
        end
        wb_addr = 5'd0;
        set_id(1, CTRL_ADD, 5'd0, 5'd0, 5'd14, 32'h0, 32'h0);
        step();
        n_cmp++;
        if (ex_rs_data !== 32'h0 || ex_rt_data !== 32'h0) begin
            n_bad++; $display("FAIL bypass_r0: got rs=%h rt=%h want 0 0", ex_rs_data, ex_rt_data);
        end
        wb_we = 0;
    endtask

    task automatic test_zero_reg();
        set_id(1, CTRL_LW, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0);
        step();
        set_id(1, CTRL_ADD, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL zero_reg_stall: got %b want 0", stall);
        end
        step();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_ctrl !== CTRL_ADD) begin
            n_bad++; $display("FAIL zero_reg_nobubble: got v=%b c=%h want v=1 c=%h", ex_valid, ex_ctrl, CTRL_ADD);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_id(1, CTRL_LW, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0);
        step();
        set_id(1, CTRL_ADD, 5'd9, 5'd8, 5'd3, 32'h0, 32'h0);
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL rststall_pre: got %b want 1", stall);
        end
        rst = 1;
        step();
        rst = 0; id_valid = 0; #1;
        n_cmp++;
        if (dut_state() !== '0 || stall !== 1'b0) begin
            n_bad++; $display("FAIL rststall_clear: got st=%h stall=%b want 0 0", dut_state(), stall);
        end
        step();
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 9'd0) begin
            n_bad++; $display("FAIL rststall_novalid: got v=%b c=%h want 0 0", ex_valid, ex_ctrl);
        end
    endtask

    task automatic test_random();
        logic exp_stall;
        ex_t  got;
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 6) == 0);
            wb_we = $urandom_range(0, 1);
            wb_addr = $urandom_range(0, 3);
            wb_data = $urandom;
            set_id($urandom_range(0, 4) != 0, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom, $urandom);
            if ($urandom_range(0, 1) == 1) id_ctrl[7] = 1'b1;
            #1;
            exp_stall = model_stall(mdl);
            n_cmp++;
            if (stall !== exp_stall) begin
                n_bad++; $display("FAIL rand_stall[%0d]: got %b want %b", i, stall, exp_stall);
            end
            step();
            got = dut_state();
            n_cmp++;
            if (got !== mdl) begin
                n_bad++; $display("FAIL rand_ex[%0d]: got %h want %h", i, got, mdl);
            end
            n_cmp++;
            if (!ex_valid && ex_ctrl !== 9'd0) begin
                n_bad++; $display("FAIL rand_ctrl_invalid[%0d]: got c=%h want 0", i, ex_ctrl);
            end
        end
        rst = 0; flush = 0; hold = 0; wb_we = 0;
    endtask

    initial begin
        mdl = '0;
        #2;
        test_reset();
        test_load_use();
        test_flush_priority();
        test_hold();
        test_bypass();
        test_zero_reg();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
